gpio_out_ctrl: RTL and testbench

//  Parametrised memory-mapped output port driver. Successor to the fixed 16-bit, single-address out driver.

---
 rtl/gpio_out_pkg.sv | 16 +
 rtl/gpio_pulse_timer.sv | 68 ++++++
 rtl/gpio_out_ctrl.sv | 103 ++++++++++
 tb/tb_gpio_out_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_out_pkg.sv
// Shared register offsets and pulse state encoding for the GPIO output driver.
package gpio_out_pkg;

  localparam logic [31:0] OFS_DATA  = 32'd0;
  localparam logic [31:0] OFS_SET   = 32'd4;
  localparam logic [31:0] OFS_CLR   = 32'd8;
  localparam logic [31:0] OFS_TGL   = 32'd12;
  localparam logic [31:0] OFS_PLEN  = 32'd16;
  localparam logic [31:0] OFS_PULSE = 32'd20;

  // One past the last mapped byte offset.
  localparam logic [31:0] OFS_END   = 32'd24;

  typedef enum logic {IDLE, ACTIVE} pulse_state_t;

endpackage

// File: rtl/gpio_pulse_timer.sv
// One-shot pulse engine: inverts a mask of pins for plen cycles, then reverts.
// mask_next exposes the post-edge mask so the pin flop can update in the same edge.
module gpio_pulse_timer
  import gpio_out_pkg::*;
#(
  parameter int PORT_WIDTH = 16,
  parameter int PCNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  trig,
  input  logic [PORT_WIDTH-1:0] trig_mask,
  input  logic [PCNT_W-1:0]     plen,
  output logic [PORT_WIDTH-1:0] mask_out,
  output logic [PORT_WIDTH-1:0] mask_next,
  output logic                  busy
);

  pulse_state_t          state_q, state_d;
  logic [PCNT_W-1:0]     cnt_q, cnt_d;
  logic [PORT_WIDTH-1:0] mask_q, mask_d;
  logic                  busy_q;

  // A new trigger always wins over the running countdown; a degenerate one aborts.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    if (trig) begin
      if ((trig_mask != '0) && (plen != '0)) begin
        state_d = ACTIVE;
        cnt_d   = plen;
        mask_d  = trig_mask;
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
        mask_d  = '0;
      end
    end else if (state_q == ACTIVE) begin
      if (cnt_q == PCNT_W'(1)) begin
        state_d = IDLE;
        cnt_d   = '0;
        mask_d  = '0;
      end else begin
        cnt_d = cnt_q - PCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mask_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      busy_q  <= (state_d == ACTIVE);
    end
  end

  assign mask_out  = mask_q;
  assign mask_next = mask_d;
  assign busy      = busy_q;

endmodule

// File: rtl/gpio_out_ctrl.sv
// Memory-mapped output port driver with DATA/SET/CLR/TGL access, a one-shot
// pulse engine and a registered read-before-write readback path.
module gpio_out_ctrl
  import gpio_out_pkg::*;
#(
  parameter int          PORT_WIDTH = 16,
  parameter logic [31:0] BASE_ADDR  = 32'd8,
  parameter int          PCNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           adress,
  input  logic [31:0]           bus_in,
  input  logic                  we,
  output logic [31:0]           bus_out,
  output logic [PORT_WIDTH-1:0] IO_port,
  output logic                  pulse_busy
);

  logic [31:0]           off;
  logic                  mapped;
  logic                  wr_en;
  logic                  trig;
  logic [PORT_WIDTH-1:0] wdata;
  logic [PORT_WIDTH-1:0] out_reg_q, out_reg_d;
  logic [PCNT_W-1:0]     plen_q, plen_d;
  logic [PORT_WIDTH-1:0] io_q, io_d;
  logic [31:0]           bus_out_q, bus_out_d;
  logic [PORT_WIDTH-1:0] mask_q, mask_next;
  logic                  busy;
  logic                  unused_bus;

  // Addresses below BASE_ADDR wrap to a huge offset and fall outside the map.
  assign off        = adress - BASE_ADDR;
  assign mapped     = (adress[1:0] == 2'b00) && (off < OFS_END);
  assign wr_en      = we && mapped;
  assign trig       = wr_en && (off == OFS_PULSE);
  assign wdata      = bus_in[PORT_WIDTH-1:0];
  assign unused_bus = ^bus_in;

  gpio_pulse_timer #(
    .PORT_WIDTH (PORT_WIDTH),
    .PCNT_W     (PCNT_W)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .trig      (trig),
    .trig_mask (wdata),
    .plen      (plen_q),
    .mask_out  (mask_q),
    .mask_next (mask_next),
    .busy      (busy)
  );

  always_comb begin
    out_reg_d = out_reg_q;
    plen_d    = plen_q;
    if (wr_en) begin
      case (off)
        OFS_DATA: out_reg_d = wdata;
        OFS_SET:  out_reg_d = out_reg_q | wdata;
        OFS_CLR:  out_reg_d = out_reg_q & ~wdata;
        OFS_TGL:  out_reg_d = out_reg_q ^ wdata;
        OFS_PLEN: plen_d    = bus_in[PCNT_W-1:0];
        default:  ;
      endcase
    end
  end

  // Readback samples the registers as they stand before this edge's write.
  always_comb begin
    bus_out_d = '0;
    if (mapped) begin
      case (off)
        OFS_DATA:  bus_out_d = 32'(out_reg_q);
        OFS_PLEN:  bus_out_d = 32'(plen_q);
        OFS_PULSE: bus_out_d = {busy, 31'b0} | 32'(mask_q);
        default:   bus_out_d = '0;
      endcase
    end
  end

  assign io_d = out_reg_d ^ mask_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_reg_q <= '0;
      plen_q    <= '0;
      io_q      <= '0;
      bus_out_q <= '0;
    end else begin
      out_reg_q <= out_reg_d;
      plen_q    <= plen_d;
      io_q      <= io_d;
      bus_out_q <= bus_out_d;
    end
  end

  assign IO_port    = io_q;
  assign bus_out    = bus_out_q;
  assign pulse_busy = busy;

endmodule

// File: tb/tb_gpio_out_ctrl.sv
// Bench for gpio_out_ctrl: directed literal checks plus randomized traffic
// compared every cycle against a behavioural register/pulse model.
module tb_gpio_out_ctrl;

  localparam logic [31:0] BASE = 32'd8;
  localparam logic [31:0] IDLE_ADDR = 32'h100;

  logic        clk;
  logic        reset;
  logic [31:0] adress;
  logic [31:0] bus_in;
  logic        we;
  logic [31:0] bus_out;
  logic [15:0] IO_port;
  logic        pulse_busy;

  int n_chk = 0;
  int n_err = 0;

  gpio_out_ctrl #(
    .PORT_WIDTH (16),
    .BASE_ADDR  (32'd8),
    .PCNT_W     (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .adress     (adress),
    .bus_in     (bus_in),
    .we         (we),
    .bus_out    (bus_out),
    .IO_port    (IO_port),
    .pulse_busy (pulse_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: pins = out ^ mask while 'remain' cycles of inversion are left.
  typedef struct packed {
    logic [15:0] out;
    logic [15:0] plen;
    logic [15:0] mask;
    logic [31:0] remain;
    logic [31:0] rd;
  } model_t;

  model_t m;

  function automatic model_t step(model_t cur, logic [31:0] a, logic [31:0] d, logic w);
    model_t r;
    logic [31:0] o;
    logic mp;
    r  = cur;
    o  = a - BASE;
    mp = (a[1:0] == 2'b00) && (a >= BASE) && (a < BASE + 32'd24);
    r.rd = 32'h0;
    if (mp) begin
      if (o == 32'd0)  r.rd = {16'h0, cur.out};
      if (o == 32'd16) r.rd = {16'h0, cur.plen};
      if (o == 32'd20) r.rd = ((cur.remain != 0) ? 32'h8000_0000 : 32'h0) | {16'h0, cur.mask};
    end
    if (r.remain != 0) r.remain = r.remain - 1;
    if (r.remain == 0) r.mask = 16'h0;
    if (w && mp) begin
      if (o == 32'd0)  r.out  = d[15:0];
      if (o == 32'd4)  r.out  = cur.out | d[15:0];
      if (o == 32'd8)  r.out  = cur.out & ~d[15:0];
      if (o == 32'd12) r.out  = cur.out ^ d[15:0];
      if (o == 32'd16) r.plen = d[15:0];
      if (o == 32'd20) begin
        if (d[15:0] != 16'h0 && cur.plen != 16'h0) begin
          r.mask   = d[15:0];
          r.remain = {16'h0, cur.plen};
        end else begin
          r.mask   = 16'h0;
          r.remain = 0;
        end
      end
    end
    return r;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) m <= '0;
    else       m <= step(m, adress, bus_in, we);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      chk("model_io",    {16'h0, IO_port},      {16'h0, m.out ^ m.mask});
      chk("model_busy",  {31'h0, pulse_busy},   {31'h0, (m.remain != 0)});
      chk("model_rdata", bus_out,               m.rd);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    adress = IDLE_ADDR;
    bus_in = 32'h0;
    we     = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    adress = a;
    bus_in = d;
    we     = 1'b1;
    cyc();
    idle_bus();
  endtask

  task automatic rd_addr(input logic [31:0] a);
    adress = a;
    bus_in = 32'h0;
    we     = 1'b0;
  endtask

  logic [31:0] addr_tbl [12] = '{32'd8, 32'd12, 32'd16, 32'd20, 32'd24, 32'd28,
                                 32'd9, 32'h15, 32'h100, 32'd0, 32'd4, 32'd32};

  initial begin
    reset = 1'b1;
    idle_bus();
    repeat (2) cyc();
    reset = 1'b0;
    cyc();
    chk("reset_io",    {16'h0, IO_port},    32'h0);
    chk("reset_rdata", bus_out,             32'h0);
    chk("reset_busy",  {31'h0, pulse_busy}, 32'h0);

    // Async reset mid-cycle with a pulse running
    wr(BASE + 0,  32'h5A5A);
    wr(BASE + 16, 32'd4);
    wr(BASE + 20, 32'h00FF);
    #2 reset = 1'b1;
    #1;
    chk("async_io",    {16'h0, IO_port},    32'h0);
    chk("async_busy",  {31'h0, pulse_busy}, 32'h0);
    chk("async_rdata", bus_out,             32'h0);
    cyc();
    reset = 1'b0;
    cyc();

    // Access operations
    wr(BASE + 0,  32'hFFFF_1234); chk("data", {16'h0, IO_port}, 32'h1234);
    wr(BASE + 4,  32'h0000_00F0); chk("set",  {16'h0, IO_port}, 32'h12F4);
    wr(BASE + 8,  32'h0000_0204); chk("clr",  {16'h0, IO_port}, 32'h10F0);
    wr(BASE + 12, 32'h0000_FFFF); chk("tgl",  {16'h0, IO_port}, 32'hEF0F);
    rd_addr(BASE + 0); bus_in = 32'h0000_0001;
    cyc(); idle_bus();
    chk("we0_io",    {16'h0, IO_port}, 32'hEF0F);
    chk("we0_rdata", bus_out,          32'hEF0F);
    wr(BASE + 13, 32'h0000_FFFF); chk("misalign", {16'h0, IO_port}, 32'hEF0F);

    // Single pulse of 3 cycles, with PULSE readback while active
    wr(BASE + 16, 32'd3);
    wr(BASE + 0,  32'h0);
    wr(BASE + 20, 32'h1);
    chk("p3_io0",   {16'h0, IO_port},    32'h1);
    chk("p3_busy0", {31'h0, pulse_busy}, 32'h1);
    rd_addr(BASE + 20);
    cyc();
    chk("p3_io1",  {16'h0, IO_port}, 32'h1);
    chk("p3_rdpl", bus_out,          32'h8000_0001);
    idle_bus();
    cyc(); chk("p3_io2", {16'h0, IO_port}, 32'h1);
    cyc(); chk("p3_io3", {16'h0, IO_port}, 32'h0);
    chk("p3_busy3", {31'h0, pulse_busy}, 32'h0);

    // Restart two cycles later, then abort
    wr(BASE + 16, 32'd5);
    wr(BASE + 20, 32'h3);
    chk("rs_io0", {16'h0, IO_port}, 32'h3);
    cyc();
    wr(BASE + 20, 32'hC);
    chk("rs_c0", {16'h0, IO_port}, 32'hC);
    for (int i = 1; i < 5; i++) begin
      cyc(); chk("rs_c", {16'h0, IO_port}, 32'hC);
    end
    cyc(); chk("rs_end", {16'h0, IO_port}, 32'h0);
    wr(BASE + 20, 32'hC);
    wr(BASE + 20, 32'h0);
    chk("abort_io",   {16'h0, IO_port},    32'h0);
    chk("abort_busy", {31'h0, pulse_busy}, 32'h0);

    // DATA write underneath a running pulse
    wr(BASE + 16, 32'd4);
    wr(BASE + 20, 32'h1);
    wr(BASE + 0,  32'h1);
    chk("ov_io1", {16'h0, IO_port}, 32'h0);
    cyc(); chk("ov_io2", {16'h0, IO_port}, 32'h0);
    cyc(); chk("ov_io3", {16'h0, IO_port}, 32'h0);
    cyc(); chk("ov_end", {16'h0, IO_port}, 32'h1);

    // Readback and reset during a long pulse
    wr(BASE + 0, 32'hABCD);
    rd_addr(BASE + 0); cyc();
    chk("rd_data", bus_out, 32'h0000_ABCD);
    rd_addr(IDLE_ADDR); cyc();
    chk("rd_unmapped", bus_out, 32'h0);
    wr(BASE + 16, 32'd10);
    wr(BASE + 20, 32'h00FF);
    cyc();
    #2 reset = 1'b1;
    #1 chk("rst_pulse_io", {16'h0, IO_port}, 32'h0);
    cyc(); cyc();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("after_rst_io",   {16'h0, IO_port},    32'h0);
      chk("after_rst_busy", {31'h0, pulse_busy}, 32'h0);
    end

    // Randomized traffic, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a;
      logic [31:0] d;
      a = addr_tbl[$urandom_range(0, 11)];
      if (a == BASE + 16) d = ($urandom() & 32'hFFFF_0000) | 32'($urandom_range(0, 6));
      else                d = $urandom();
      if ($urandom_range(0, 7) == 0) d = 32'h0;
      adress = a;
      bus_in = d;
      we     = ($urandom_range(0, 3) != 0);
      cyc();
    end
    idle_bus();
    cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
